fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 123 ++++++++++++
 tb/tb_fetch_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: streams 16-bit words from code memory into a
// single instruction register, with stall, redirect, halt detection and restart.
module fetch_ctrl #(
    parameter logic [4:0] HALT_OP = 5'b11111
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [7:0]  addr,
    input  logic [15:0] data,
    output logic [15:0] ir,
    output logic [7:0]  ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        jump,
    input  logic [7:0]  jump_addr,
    output logic        halted,
    output logic        busy,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [7:0]  pc_r, pc_s;
    logic [15:0] ir_r, ir_s;
    logic [7:0]  ir_pc_r, ir_pc_s;
    logic        ir_valid_r, ir_valid_s;
    logic [15:0] count_r, count_s;
    logic        accept_s;
    logic        load_s;

    assign accept_s = ir_valid_r & ir_ready;
    assign load_s   = ~ir_valid_r | ir_ready;

    // Next-state and datapath update for the three-state fetch FSM
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        ir_s       = ir_r;
        ir_pc_s    = ir_pc_r;
        ir_valid_s = ir_valid_r;
        count_s    = count_r;
        case (state_r)
            IDLE, HALT: begin
                if (start) begin
                    state_s    = RUN;
                    pc_s       = 8'd0;
                    ir_valid_s = 1'b0;
                    count_s    = 16'd0;
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                if (start) begin
                    pc_s       = 8'd0;
                    ir_valid_s = 1'b0;
                    count_s    = 16'd0;
                end else begin
                    // the instruction leaving ir counts even if this cycle flushes or halts
                    if (accept_s && (count_r != 16'hFFFF)) begin
                        count_s = count_r + 16'd1;
                    end else begin
                        count_s = count_r;
                    end
                    if (jump) begin
                        pc_s       = jump_addr;
                        ir_valid_s = 1'b0;
                    end else if (load_s) begin
                        if (data[15:11] == HALT_OP) begin
                            ir_valid_s = 1'b0;
                            state_s    = HALT;
                        end else begin
                            ir_s       = data;
                            ir_pc_s    = pc_r;
                            ir_valid_s = 1'b1;
                            pc_s       = pc_r + 8'd1;
                        end
                    end else begin
                        pc_s = pc_r;
                    end
                end
            end
            default: begin
                state_s    = IDLE;
                ir_valid_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            pc_r       <= 8'd0;
            ir_r       <= 16'h0000;
            ir_pc_r    <= 8'd0;
            ir_valid_r <= 1'b0;
            count_r    <= 16'd0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            ir_r       <= ir_s;
            ir_pc_r    <= ir_pc_s;
            ir_valid_r <= ir_valid_s;
            count_r    <= count_s;
        end
    end

    assign addr        = pc_r;
    assign ir          = ir_r;
    assign ir_pc       = ir_pc_r;
    assign ir_valid    = ir_valid_r;
    assign fetch_count = count_r;
    assign busy        = (state_r == RUN);
    assign halted      = (state_r == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run,
// every cycle compared against a behavioural model of the fetch rules.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        jump;
    logic [7:0]  jump_addr;
    logic        halted;
    logic        busy;
    logic [15:0] fetch_count;

    logic [15:0] mem [256];
    int checks = 0;
    int errors = 0;

    // model state: running / stopped-on-halt flags, otherwise idle
    bit          m_run, m_halt;
    int          m_pc, m_irpc, m_cnt;
    logic [15:0] m_ir;
    bit          m_v;

    fetch_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .addr(addr), .data(data),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .jump(jump), .jump_addr(jump_addr), .halted(halted), .busy(busy),
        .fetch_count(fetch_count)
    );

    assign data = mem[addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rnd_word();
        logic [15:0] w;
        w = 16'($urandom);
        if (w[15:11] == 5'h1F) w[15] = 1'b0;
        return w;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".addr"},     32'(addr),        32'(m_pc));
        chk({tag, ".ir"},       32'(ir),          32'(m_ir));
        chk({tag, ".ir_pc"},    32'(ir_pc),       32'(m_irpc));
        chk({tag, ".ir_valid"}, 32'(ir_valid),    32'(m_v));
        chk({tag, ".count"},    32'(fetch_count), 32'(m_cnt));
        chk({tag, ".busy"},     32'(busy),        32'(m_run));
        chk({tag, ".halted"},   32'(halted),      32'(m_halt));
    endtask

    task automatic model_reset();
        m_run = 0; m_halt = 0; m_pc = 0; m_irpc = 0; m_cnt = 0; m_v = 0;
        m_ir = 16'h0000;
    endtask

    // apply the fetch rules for one clock using the inputs present now
    task automatic model_step();
        logic [15:0] w;
        bit acc;
        acc = m_v && ir_ready;
        if (!m_run) begin
            if (start) begin
                m_run = 1; m_halt = 0; m_pc = 0; m_v = 0; m_cnt = 0;
            end
        end else if (start) begin
            m_pc = 0; m_v = 0; m_cnt = 0;
        end else begin
            if (acc && m_cnt < 65535) m_cnt++;
            if (jump) begin
                m_pc = int'(jump_addr); m_v = 0;
            end else if (!m_v || ir_ready) begin
                w = mem[m_pc];
                if (w[15:11] == 5'h1F) begin
                    m_v = 0; m_run = 0; m_halt = 1;
                end else begin
                    m_ir = w; m_irpc = m_pc; m_v = 1; m_pc = (m_pc + 1) % 256;
                end
            end
        end
    endtask

    task automatic tick(string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; ir_ready = 1'b0; jump = 1'b0; jump_addr = 8'd0;
        for (int i = 0; i < 256; i++) mem[i] = rnd_word();
        model_reset();
        #3;
        check_all("reset");
        @(posedge clk); #1;
        check_all("reset_hold");
        #3 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick("idle_wait");

        // streaming into a halt word
        mem[0] = 16'h1001; mem[1] = 16'h1002; mem[2] = 16'h1003; mem[3] = 16'hF800;
        start = 1'b1; ir_ready = 1'b1;
        tick("stream_start");
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick("stream");
        chk("stream_halted", 32'(halted), 32'd1);
        chk("stream_addr", 32'(addr), 32'd3);
        chk("stream_count", 32'(fetch_count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            jump = 1'b1; jump_addr = 8'h22;
            tick("halt_ignores");
        end
        jump = 1'b0;

        // restart from HALT, then stall on the second word
        mem[3] = 16'h1004;
        start = 1'b1; ir_ready = 1'b0;
        tick("restart");
        chk("restart_count", 32'(fetch_count), 32'd0);
        start = 1'b0;
        tick("restart_load");
        chk("restart_irpc", 32'(ir_pc), 32'd0);
        ir_ready = 1'b1;
        tick("to_1002");
        ir_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick("stall");
            chk("stall_ir", 32'(ir), 32'h1002);
            chk("stall_pc", 32'(addr), 32'd2);
        end
        ir_ready = 1'b1;
        tick("release");
        chk("release_ir", 32'(ir), 32'h1003);

        // jump flush while stalled
        ir_ready = 1'b0; jump = 1'b1; jump_addr = 8'h40;
        tick("jump");
        chk("jump_addr", 32'(addr), 32'h40);
        jump = 1'b0;
        tick("jump_load");
        chk("jump_irpc", 32'(ir_pc), 32'h40);

        // wrap from FF to 00
        mem[8'hFF] = 16'h2FFF; mem[0] = 16'h1001;
        ir_ready = 1'b1; jump = 1'b1; jump_addr = 8'hFF;
        tick("wrap_jump");
        jump = 1'b0;
        tick("wrap_ff");
        chk("wrap_ff_irpc", 32'(ir_pc), 32'hFF);
        tick("wrap_00");
        chk("wrap_00_irpc", 32'(ir_pc), 32'h00);

        // start and jump together: start wins
        start = 1'b1; jump = 1'b1; jump_addr = 8'h77;
        tick("start_jump");
        chk("start_jump_pc", 32'(addr), 32'd0);
        start = 1'b0; jump = 1'b0;
        for (int i = 0; i < 2; i++) tick("pre_reset");

        // short asynchronous reset pulse mid-run
        #2 reset_n = 1'b0;
        #2;
        model_reset();
        check_all("async_reset");
        #2 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick("after_reset");

        // randomized run with occasional halt words
        for (int i = 0; i < 256; i++) begin
            mem[i] = rnd_word();
            if ($urandom_range(0, 40) == 0) mem[i][15:11] = 5'h1F;
        end
        for (int n = 0; n < 600; n++) begin
            start     = ($urandom_range(0, 24) == 0);
            jump      = ($urandom_range(0, 7) == 0);
            jump_addr = 8'($urandom);
            ir_ready  = ($urandom_range(0, 3) != 0);
            tick("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
